dmem_resp: RTL and testbench
============================

Name: dmem_resp

Overview:
- Data-memory responder at the far end of the MO-stage memory interface.
- Accepts single-word (24-bit) and dual-word (48-bit, little-endian lo/hi) read/write requests and services them on one single-port synchronous SRAM.
- Dual-word requests are serialized over two SRAM cycles, with a stall back to the pipeline.
- Returns read data to the MO stage as a 2-word array: word k holds the data for address addr+k.

Parameters:
- DEPTH_W, 16, SRAM word-address width; the SRAM holds 2^DEPTH_W 24-bit words.
- SIZE_DATA, 24, data word width (matches the shared sizes include).
- SIZE_ADDR, 48, request address width (matches the shared sizes include).

Ports:
- iw_clk  in  1  clock
- iw_rst_n  in  1  reset, asynchronous, active-low
- iw_req  in  1  request valid; held stable by upstream while ow_stall=1
- iw_req_addr  in  SIZE_ADDR  word address of word 0
- iw_req_dual  in  1  1 = access both words (addr, addr+1); 0 = single word
- iw_req_mp  in  1  selects the word for single access; word mp targets addr+mp
- iw_req_we  in  2  per-word write enable, bit k refers to word k
- iw_req_wdata  in  SIZE_DATA x [0:1]  write data per word
- ow_stall  out  1  upstream must hold the request
- ow_rvalid  out  1  one-cycle pulse: ow_rdata updated
- ow_rdata  out  SIZE_DATA x [0:1]  read data per word
- ow_oob  out  1  one-cycle pulse: request address bits above DEPTH_W were nonzero
- ow_sram_en  out  1  SRAM access enable
- ow_sram_we  out  1  SRAM write enable
- ow_sram_addr  out  DEPTH_W  SRAM address
- ow_sram_wdata  out  SIZE_DATA  SRAM write data
- iw_sram_rdata  in  SIZE_DATA  SRAM read data, valid the cycle after an en=1, we=0 access

Behaviour:
- Reset (iw_rst_n=0, any time, including mid-access):
  - state=IDLE; all outputs 0; ow_rdata words 0.
  - An in-flight access is abandoned and no rvalid is produced.
- FSM states: IDLE, HI, FIN. ACCEPT is true when state is IDLE or FIN.
- SRAM drive is combinational in ACCEPT states and from latched request registers in HI.
- ACCEPT with iw_req=1 and iw_req_dual=0 (single access):
  - Drive the SRAM for word mp: addr+mp truncated to DEPTH_W, we=iw_req_we[mp], wdata=iw_req_wdata[mp].
  - Next state: FIN if the word is a read, else IDLE.
  - ow_stall=0.
- ACCEPT with iw_req=1 and iw_req_dual=1:
  - Drive word 0 at addr[DEPTH_W-1:0].
  - Latch addr, we, wdata[1] and the read mask.
  - ow_stall=1 combinationally this cycle; next state HI.
- HI:
  - Drive word 1 at (addr+1) mod 2^DEPTH_W; this wraps 2^DEPTH_W-1 to 0.
  - If word 0 was a read, capture iw_sram_rdata into ow_rdata[0].
  - ow_stall=1; next state FIN if any word is a read, else IDLE.
- FIN:
  - Capture the pending read word from iw_sram_rdata into ow_rdata[k].
  - Pulse ow_rvalid=1.
  - A new request is accepted in the same cycle (back-to-back, no bubble).
- Stall:
  - ow_stall = (ACCEPT & iw_req & iw_req_dual) | (state==HI).
- ow_rdata:
  - Words not read by the current access keep their previous value.
- Latency:
  - Single read: rvalid at N+1.
  - Dual read: rvalid at N+2.
  - Writes: no rvalid; the SRAM is written in the issuing cycle.
- ow_oob:
  - Registered; pulses the cycle after a request is accepted whose addr bits above DEPTH_W, or of addr+1 for words targeting addr+1, are nonzero.
  - The access still proceeds, using the truncated address.
- iw_req=0 in an ACCEPT state: ow_sram_en=0 and the state goes to IDLE; no SRAM activity.
- Per-word we differing in a dual access (one read, one write) is legal and each word is honored.

Decomposition:
- Shared package/include: state encoding (IDLE/HI/FIN), and SIZE_DATA/SIZE_ADDR from the existing sizes include.
- One natural sub-module, dmem_sram_model: behavioral single-port SRAM with 1-cycle read latency.
  - Used by the bench and FPGA builds; not instantiated inside dmem_resp.

Test Plan:
- Reset: hold iw_rst_n=0 with iw_req=1 -> all outputs 0; release -> IDLE, ow_stall=0.
- Single write then read: write addr=0x10, mp=1, wdata[1]=0xABCDEF -> SRAM[0x11]=0xABCDEF. Read the same word -> rvalid at N+1, ow_rdata[1]=0xABCDEF, ow_rdata[0] unchanged.
- Dual write/read: write addr=0x20, wdata={0x123456, 0x654321} -> stall high 1 cycle. Read back -> stall 1 cycle, rvalid at N+2, rdata[0]=0x654321, rdata[1]=0x123456.
- Wrap/oob:
  - Dual access at addr=0xFFFF (DEPTH_W=16) -> word 1 hits SRAM 0x0000, ow_oob pulses.
  - Single access at addr=0x1_0005 -> SRAM 0x0005, ow_oob pulses.
- Back-to-back: dual read immediately followed by a single read accepted in FIN -> rvalid on consecutive cycles, correct data, no extra stall.
- Reset mid-op: assert iw_rst_n=0 in HI of a dual read -> no rvalid, state IDLE, ow_rdata=0, SRAM en=0.

Source files
------------

// File: rtl/dmem_resp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dmem_resp_pkg                                                 |
// | Purpose  : Shared sizes and FSM state encoding for the data-memory       |
// |            responder and its behavioural SRAM.                           |
// | Contents : DMEM_SIZE_DATA - data word width (24)                         |
// |            DMEM_SIZE_ADDR - request address width (48)                   |
// |            state_e        - responder FSM states IDLE / HI / FIN         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package dmem_resp_pkg;

   localparam int DMEM_SIZE_DATA = 24;
   localparam int DMEM_SIZE_ADDR = 48;

   // IDLE : nothing in flight
   // HI   : second word of a dual access is being driven to the SRAM
   // FIN  : read data for the last issued word is on the SRAM output
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HI   = 2'd1,
      FIN  = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_sram_model.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dmem_sram_model                                               |
// | Purpose  : Behavioural single-port synchronous SRAM, one-cycle read      |
// |            latency. Used next to dmem_resp in benches and FPGA builds.   |
// | Ports    : iw_clk    - clock                                             |
// |            iw_en     - access enable                                     |
// |            iw_we     - write enable (read when 0)                        |
// |            iw_addr   - word address                                      |
// |            iw_wdata  - write data                                        |
// |            ow_rdata  - read data, valid the cycle after a read access    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dmem_sram_model
   import dmem_resp_pkg::*;
#(
   parameter int DEPTH_W   = 16,
   parameter int SIZE_DATA = DMEM_SIZE_DATA
)(
   input  logic                 iw_clk,
   input  logic                 iw_en,
   input  logic                 iw_we,
   input  logic [DEPTH_W-1:0]   iw_addr,
   input  logic [SIZE_DATA-1:0] iw_wdata,
   output logic [SIZE_DATA-1:0] ow_rdata
);

   logic [SIZE_DATA-1:0] mem [0:(2**DEPTH_W)-1];
   logic [SIZE_DATA-1:0] rdata_q;
   logic [SIZE_DATA-1:0] rdata_d;

   // Read port holds its last value when no read is issued.
   always_comb begin
      rdata_d = rdata_q;
      if (iw_en && !iw_we) begin
         rdata_d = mem[iw_addr];
      end
   end

   always_ff @(posedge iw_clk) begin
      rdata_q <= rdata_d;
      if (iw_en && iw_we) begin
         mem[iw_addr] <= iw_wdata;
      end
   end

   assign ow_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_resp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dmem_resp                                                     |
// | Purpose  : Data-memory responder. Services single-word and dual-word     |
// |            (little-endian lo/hi) read/write requests on one single-port  |
// |            SRAM, serialising dual accesses over two SRAM cycles.         |
// | Ports    : iw_clk, iw_rst_n      - clock, async active-low reset         |
// |            iw_req*               - request (held while ow_stall=1)       |
// |            ow_stall              - upstream must hold the request        |
// |            ow_rvalid / ow_rdata  - read return, word k = addr+k          |
// |            ow_oob                - address bits above the SRAM range set |
// |            ow_sram_* / iw_sram_rdata - SRAM port                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dmem_resp
   import dmem_resp_pkg::*;
#(
   parameter int DEPTH_W   = 16,
   parameter int SIZE_DATA = DMEM_SIZE_DATA,
   parameter int SIZE_ADDR = DMEM_SIZE_ADDR
)(
   input  logic                 iw_clk,
   input  logic                 iw_rst_n,
   input  logic                 iw_req,
   input  logic [SIZE_ADDR-1:0] iw_req_addr,
   input  logic                 iw_req_dual,
   input  logic                 iw_req_mp,
   input  logic [1:0]           iw_req_we,
   input  logic [SIZE_DATA-1:0] iw_req_wdata [0:1],
   output logic                 ow_stall,
   output logic                 ow_rvalid,
   output logic [SIZE_DATA-1:0] ow_rdata [0:1],
   output logic                 ow_oob,
   output logic                 ow_sram_en,
   output logic                 ow_sram_we,
   output logic [DEPTH_W-1:0]   ow_sram_addr,
   output logic [SIZE_DATA-1:0] ow_sram_wdata,
   input  logic [SIZE_DATA-1:0] iw_sram_rdata
);

   state_e               state_q,    state_d;
   logic [DEPTH_W-1:0]   addr_q,     addr_d;      // truncated word-0 address
   logic [1:0]           we_q,       we_d;        // latched per-word write enables
   logic [SIZE_DATA-1:0] wdata1_q,   wdata1_d;    // latched word-1 write data
   logic [1:0]           fin_mask_q, fin_mask_d;  // word captured in FIN
   logic                 rvalid_q,   rvalid_d;
   logic                 oob_q,      oob_d;
   logic [SIZE_DATA-1:0] rdata_q [0:1];
   logic [SIZE_DATA-1:0] rdata_d [0:1];

   logic                 sram_en;
   logic                 sram_we;
   logic [DEPTH_W-1:0]   sram_addr;
   logic [SIZE_DATA-1:0] sram_wdata;
   logic                 stall;

   logic [SIZE_ADDR-1:0] addr_p1;
   logic                 upper0_nz;
   logic                 upper1_nz;

   assign addr_p1   = iw_req_addr + SIZE_ADDR'(1);
   assign upper0_nz = |iw_req_addr[SIZE_ADDR-1:DEPTH_W];
   assign upper1_nz = |addr_p1[SIZE_ADDR-1:DEPTH_W];

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata1_d   = wdata1_q;
      fin_mask_d = fin_mask_q;
      rdata_d    = rdata_q;
      rvalid_d   = 1'b0;
      oob_d      = 1'b0;
      sram_en    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
      stall      = 1'b0;

      if (state_q == HI) begin
         // Word 0 was issued last cycle; its read data is on the SRAM now.
         if (!we_q[0]) begin
            rdata_d[0] = iw_sram_rdata;
         end
         sram_en    = 1'b1;
         sram_we    = we_q[1];
         sram_addr  = addr_q + DEPTH_W'(1);   // wraps at the top of the SRAM
         sram_wdata = wdata1_q;
         stall      = 1'b1;
         fin_mask_d = {~we_q[1], 1'b0};
         state_d    = (we_q == 2'b11) ? IDLE : FIN;
      end else begin
         // IDLE and FIN both accept a new request.
         if (state_q == FIN) begin
            for (int k = 0; k < 2; k++) begin
               if (fin_mask_q[k]) begin
                  rdata_d[k] = iw_sram_rdata;
               end
            end
            rvalid_d = 1'b1;
         end
         state_d = IDLE;
         if (iw_req) begin
            sram_en = 1'b1;
            if (iw_req_dual) begin
               sram_we    = iw_req_we[0];
               sram_addr  = iw_req_addr[DEPTH_W-1:0];
               sram_wdata = iw_req_wdata[0];
               addr_d     = iw_req_addr[DEPTH_W-1:0];
               we_d       = iw_req_we;
               wdata1_d   = iw_req_wdata[1];
               stall      = 1'b1;
               oob_d      = upper0_nz | upper1_nz;
               state_d    = HI;
            end else begin
               sram_we    = iw_req_we[iw_req_mp];
               sram_addr  = iw_req_mp ? addr_p1[DEPTH_W-1:0] : iw_req_addr[DEPTH_W-1:0];
               sram_wdata = iw_req_wdata[iw_req_mp];
               fin_mask_d = iw_req_mp ? 2'b10 : 2'b01;
               oob_d      = iw_req_mp ? upper1_nz : upper0_nz;
               state_d    = iw_req_we[iw_req_mp] ? IDLE : FIN;
            end
         end
      end
   end

   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         we_q       <= '0;
         wdata1_q   <= '0;
         fin_mask_q <= '0;
         rvalid_q   <= 1'b0;
         oob_q      <= 1'b0;
         rdata_q    <= '{default: '0};
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata1_q   <= wdata1_d;
         fin_mask_q <= fin_mask_d;
         rvalid_q   <= rvalid_d;
         oob_q      <= oob_d;
         rdata_q    <= rdata_d;
      end
   end

   // The combinational outputs follow the request directly, so they are
   // forced low while reset is asserted to keep the SRAM quiet.
   assign ow_stall      = iw_rst_n & stall;
   assign ow_sram_en    = iw_rst_n & sram_en;
   assign ow_sram_we    = iw_rst_n & sram_we;
   assign ow_sram_addr  = iw_rst_n ? sram_addr  : '0;
   assign ow_sram_wdata = iw_rst_n ? sram_wdata : '0;

   assign ow_rvalid = rvalid_q;
   assign ow_oob    = oob_q;
   assign ow_rdata  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dmem_resp                                                  |
// | Purpose  : Self-checking bench for dmem_resp with the behavioural SRAM.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dmem_resp;
   import dmem_resp_pkg::*;

   localparam int DEPTH_W = 16;
   localparam int SD      = 24;
   localparam int SA      = 48;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          req   = 1'b0;
   logic [SA-1:0] addr  = '0;
   logic          dual  = 1'b0;
   logic          mp    = 1'b0;
   logic [1:0]    we    = '0;
   logic [SD-1:0] wdata [0:1];
   logic          stall, rvalid, oob, sen, swe;
   logic [SD-1:0] rdata [0:1];
   logic [DEPTH_W-1:0] saddr;
   logic [SD-1:0] swdata, srdata;

   dmem_resp #(.DEPTH_W(DEPTH_W), .SIZE_DATA(SD), .SIZE_ADDR(SA)) dut (
      .iw_clk(clk), .iw_rst_n(rst_n), .iw_req(req), .iw_req_addr(addr),
      .iw_req_dual(dual), .iw_req_mp(mp), .iw_req_we(we), .iw_req_wdata(wdata),
      .ow_stall(stall), .ow_rvalid(rvalid), .ow_rdata(rdata), .ow_oob(oob),
      .ow_sram_en(sen), .ow_sram_we(swe), .ow_sram_addr(saddr),
      .ow_sram_wdata(swdata), .iw_sram_rdata(srdata)
   );

   dmem_sram_model #(.DEPTH_W(DEPTH_W), .SIZE_DATA(SD)) u_sram (
      .iw_clk(clk), .iw_en(sen), .iw_we(swe), .iw_addr(saddr),
      .iw_wdata(swdata), .ow_rdata(srdata)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Word-level reference: memory image plus last returned word per slot.
   logic [SD-1:0] ref_mem [0:(2**DEPTH_W)-1];
   logic [SD-1:0] ref_rd  [0:1];

   typedef struct {
      bit          d;
      logic [47:0] a;
      bit          m;
      logic [1:0]  w;
      logic [23:0] wd0;
      logic [23:0] wd1;
      int          lat;
      logic [47:0] rd;     // {word1, word0}
      bit          oob;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input bit d, input logic [47:0] a, input bit m,
                               input logic [1:0] w, input logic [23:0] wd0,
                               input logic [23:0] wd1, input int lat,
                               input logic [47:0] rd, input bit o);
      vec_t v;
      v.d = d; v.a = a; v.m = m; v.w = w; v.wd0 = wd0; v.wd1 = wd1;
      v.lat = lat; v.rd = rd; v.oob = o;
      return v;
   endfunction

   // Applies one request to the reference and predicts what the DUT returns.
   task automatic model_step(input bit d, input logic [47:0] a, input bit m,
                             input logic [1:0] w, input logic [23:0] wd0,
                             input logic [23:0] wd1, output int lat,
                             output logic [47:0] rd, output bit oob_e);
      bit          any_rd;
      logic [47:0] wa;
      logic [15:0] sa;
      any_rd = 1'b0;
      oob_e  = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if (d || k == int'(m)) begin
            wa = a + 48'(k);
            sa = wa[15:0];
            if (wa[47:16] != 32'd0) oob_e = 1'b1;
            if (w[k]) ref_mem[sa] = (k == 0) ? wd0 : wd1;
            else begin
               ref_rd[k] = ref_mem[sa];
               any_rd    = 1'b1;
            end
         end
      end
      lat = !any_rd ? 0 : (d ? 2 : 1);
      rd  = {ref_rd[1], ref_rd[0]};
   endtask

   // Drives one request at a falling edge and checks SRAM drive, stall,
   // oob pulse, rvalid latency/count and the returned words.
   task automatic issue(input string tag, input bit d, input logic [47:0] a,
                        input bit m, input logic [1:0] w, input logic [23:0] wd0,
                        input logic [23:0] wd1, input int exp_lat,
                        input logic [47:0] exp_rd, input bit exp_oob);
      logic [47:0] a1;
      int          seen;
      int          pulses;
      a1 = a + 48'd1;
      req = 1'b1; dual = d; addr = a; mp = m; we = w;
      wdata[0] = wd0; wdata[1] = wd1;
      #1;
      chk({tag, " stall0"}, 64'(stall), 64'(d));
      chk({tag, " en0"}, 64'(sen), 64'd1);
      if (d || !m) begin
         chk({tag, " addr0"}, 64'(saddr), 64'(a[15:0]));
         chk({tag, " we0"}, 64'(swe), 64'(w[0]));
         if (w[0]) chk({tag, " wdata0"}, 64'(swdata), 64'(wd0));
      end else begin
         chk({tag, " addr0"}, 64'(saddr), 64'(a1[15:0]));
         chk({tag, " we0"}, 64'(swe), 64'(w[1]));
         if (w[1]) chk({tag, " wdata0"}, 64'(swdata), 64'(wd1));
      end
      @(posedge clk); @(negedge clk);
      chk({tag, " oob"}, 64'(oob), 64'(exp_oob));
      if (d) begin
         chk({tag, " stall1"}, 64'(stall), 64'd1);
         chk({tag, " en1"}, 64'(sen), 64'd1);
         chk({tag, " addr1"}, 64'(saddr), 64'(a1[15:0]));
         chk({tag, " we1"}, 64'(swe), 64'(w[1]));
         if (w[1]) chk({tag, " wdata1"}, 64'(swdata), 64'(wd1));
         @(posedge clk); @(negedge clk);
      end
      req    = 1'b0;
      seen   = 0;
      pulses = 0;
      for (int i = (d ? 1 : 0); i <= 3; i++) begin
         if (rvalid) begin
            pulses++;
            if (seen == 0) seen = i;
         end
         if (i < 3) begin
            @(posedge clk); @(negedge clk);
         end
      end
      chk({tag, " latency"}, 64'(seen), 64'(exp_lat));
      chk({tag, " rvalid_count"}, 64'(pulses), 64'((exp_lat != 0) ? 1 : 0));
      chk({tag, " rdata0"}, 64'(rdata[0]), 64'(exp_rd[23:0]));
      chk({tag, " rdata1"}, 64'(rdata[1]), 64'(exp_rd[47:24]));
      chk({tag, " stall_idle"}, 64'(stall), 64'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " stall"}, 64'(stall), 64'd0);
      chk({tag, " rvalid"}, 64'(rvalid), 64'd0);
      chk({tag, " oob"}, 64'(oob), 64'd0);
      chk({tag, " en"}, 64'(sen), 64'd0);
      chk({tag, " we"}, 64'(swe), 64'd0);
      chk({tag, " saddr"}, 64'(saddr), 64'd0);
      chk({tag, " swdata"}, 64'(swdata), 64'd0);
      chk({tag, " rdata0"}, 64'(rdata[0]), 64'd0);
      chk({tag, " rdata1"}, 64'(rdata[1]), 64'd0);
   endtask

   initial begin
      int          lat;
      logic [47:0] rd;
      bit          o;
      logic [15:0] lo;
      logic [31:0] hi;
      int          r;
      bit          rd_d, rd_m;
      logic [1:0]  rd_w;

      wdata[0] = '0; wdata[1] = '0;
      ref_rd[0] = '0; ref_rd[1] = '0;

      tbl[0]  = mk(0, 48'h10,      1, 2'b10, 24'h0,      24'hABCDEF, 0, {24'h0,      24'h0},      0);
      tbl[1]  = mk(0, 48'h10,      1, 2'b00, 24'h0,      24'h0,      1, {24'hABCDEF, 24'h0},      0);
      tbl[2]  = mk(1, 48'h20,      0, 2'b11, 24'h654321, 24'h123456, 0, {24'hABCDEF, 24'h0},      0);
      tbl[3]  = mk(1, 48'h20,      0, 2'b00, 24'h0,      24'h0,      2, {24'h123456, 24'h654321}, 0);
      tbl[4]  = mk(1, 48'hFFFF,    0, 2'b11, 24'h111111, 24'h222222, 0, {24'h123456, 24'h654321}, 1);
      tbl[5]  = mk(0, 48'h0,       0, 2'b00, 24'h0,      24'h0,      1, {24'h123456, 24'h222222}, 0);
      tbl[6]  = mk(0, 48'h1_0005,  0, 2'b01, 24'h0A0B0C, 24'h0,      0, {24'h123456, 24'h222222}, 1);
      tbl[7]  = mk(0, 48'h5,       0, 2'b00, 24'h0,      24'h0,      1, {24'h123456, 24'h0A0B0C}, 0);
      tbl[8]  = mk(0, 48'h30,      1, 2'b10, 24'h0,      24'h313131, 0, {24'h123456, 24'h0A0B0C}, 0);
      tbl[9]  = mk(1, 48'h30,      0, 2'b01, 24'h777777, 24'h0,      2, {24'h313131, 24'h0A0B0C}, 0);
      tbl[10] = mk(0, 48'h30,      0, 2'b00, 24'h0,      24'h0,      1, {24'h313131, 24'h777777}, 0);
      tbl[11] = mk(1, 48'h20,      0, 2'b10, 24'h0,      24'h999999, 2, {24'h313131, 24'h654321}, 0);
      tbl[12] = mk(0, 48'h20,      1, 2'b00, 24'h0,      24'h0,      1, {24'h999999, 24'h654321}, 0);
      tbl[13] = mk(0, 48'hFFFF,    1, 2'b00, 24'h0,      24'h0,      1, {24'h222222, 24'h654321}, 1);

      // Reset held with a live request: everything quiet.
      rst_n = 1'b0; req = 1'b1; dual = 1'b1; mp = 1'b1; we = 2'b11;
      addr = 48'h1_0000_FFFF; wdata[0] = 24'h5A5A5A; wdata[1] = 24'hA5A5A5;
      repeat (2) @(negedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      req = 1'b0; rst_n = 1'b1;
      #1;
      chk("post_reset stall", 64'(stall), 64'd0);
      chk("post_reset en", 64'(sen), 64'd0);
      @(posedge clk); @(negedge clk);
      chk("post_reset rvalid", 64'(rvalid), 64'd0);

      // Directed vectors.
      for (int i = 0; i < 14; i++) begin
         model_step(tbl[i].d, tbl[i].a, tbl[i].m, tbl[i].w, tbl[i].wd0, tbl[i].wd1, lat, rd, o);
         issue($sformatf("vec%0d", i), tbl[i].d, tbl[i].a, tbl[i].m, tbl[i].w,
               tbl[i].wd0, tbl[i].wd1, tbl[i].lat, tbl[i].rd, tbl[i].oob);
      end

      // Back-to-back: dual read at 0x20, single read of 0x30 accepted in FIN.
      req = 1'b1; dual = 1'b1; addr = 48'h20; mp = 1'b0; we = 2'b00;
      @(posedge clk); @(negedge clk);
      chk("b2b hi stall", 64'(stall), 64'd1);
      @(posedge clk); @(negedge clk);
      chk("b2b fin rvalid", 64'(rvalid), 64'd0);
      dual = 1'b0; addr = 48'h30; mp = 1'b0; we = 2'b00;
      #1;
      chk("b2b accept stall", 64'(stall), 64'd0);
      chk("b2b accept en", 64'(sen), 64'd1);
      chk("b2b accept addr", 64'(saddr), 64'h30);
      @(posedge clk); @(negedge clk);
      req = 1'b0;
      chk("b2b rv1", 64'(rvalid), 64'd1);
      chk("b2b rv1 rdata0", 64'(rdata[0]), 64'h654321);
      chk("b2b rv1 rdata1", 64'(rdata[1]), 64'h999999);
      @(posedge clk); @(negedge clk);
      chk("b2b rv2", 64'(rvalid), 64'd1);
      chk("b2b rv2 rdata0", 64'(rdata[0]), 64'h777777);
      chk("b2b rv2 rdata1", 64'(rdata[1]), 64'h999999);
      @(posedge clk); @(negedge clk);
      chk("b2b done", 64'(rvalid), 64'd0);

      // Reset asserted while in HI of a dual read.
      req = 1'b1; dual = 1'b1; addr = 48'h20; we = 2'b00;
      @(posedge clk); @(negedge clk);
      req = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         chk("midreset no_rvalid", 64'(rvalid), 64'd0);
      end
      chk("midreset rdata0", 64'(rdata[0]), 64'd0);
      ref_rd[0] = '0; ref_rd[1] = '0;

      // Fill the random address pool so every later read has a known value.
      for (int i = 0; i < 33; i++) begin
         lo = (i < 17) ? 16'(i) : 16'(16'hFFF0 + 16'(i - 17));
         model_step(0, {32'd0, lo}, 0, 2'b01, 24'($urandom), 24'h0, lat, rd, o);
         issue("fill", 0, {32'd0, lo}, 0, 2'b01, ref_mem[lo], 24'h0, lat, rd, o);
      end

      // Random mix against the reference.
      for (int i = 0; i < 150; i++) begin
         logic [23:0] w0, w1;
         r    = int'($urandom_range(0, 31));
         lo   = (r < 16) ? 16'(r) : 16'(16'hFFF0 + 16'(r - 16));
         hi   = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
         rd_d = 1'($urandom);
         rd_m = 1'($urandom);
         rd_w = 2'($urandom);
         w0   = 24'($urandom);
         w1   = 24'($urandom);
         model_step(rd_d, {hi, lo}, rd_m, rd_w, w0, w1, lat, rd, o);
         issue($sformatf("rnd%0d", i), rd_d, {hi, lo}, rd_m, rd_w, w0, w1, lat, rd, o);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
